// File: rtl/uart_pkg.sv
// Shared UART types and default constants, used by both the RX deserializer and the TX serializer.
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate sample tick generator: one-cycle tick every baud_div_i+1 clocks.
// A synchronous clear restarts the count so that the tick phase can be aligned to an external event.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign tick_o = (div_cnt_q == baud_div_i);

    // A clear takes priority over the wrap, so the first tick after a clear lands baud_div_i+1 cycles later.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (clr_i || tick_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversamples rx_i, frames start/data/parity/stop,
// writes good bytes to the RX FIFO, and pulses frame, parity and overrun errors.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEF,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DIV_W      = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] fifo_din,
    output logic                 fifo_wr_en,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int B_W = $clog2(DATA_BITS + 1);
    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BITS - 1);

    uart_rx_state_t       state_q, state_d;
    logic                 rx_meta_q, rxs_q;
    logic [S_W-1:0]       s_cnt_q, s_cnt_d;
    logic [B_W-1:0]       b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] din_q, din_d;
    logic                 wr_q, wr_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_pulse_q, perr_pulse_d;
    logic                 ovr_q, ovr_d;
    logic                 div_clr;
    logic                 tick;
    logic                 sample_mid;
    logic                 sample_last;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk        (wr_clk),
        .rst        (rst),
        .clr_i      (div_clr),
        .baud_div_i (baud_div),
        .tick_o     (tick)
    );

    // Two-flop synchronizer; idle-high reset value keeps a reset from looking like a start bit.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    assign sample_mid  = tick && (s_cnt_q == S_MID);
    assign sample_last = tick && (s_cnt_q == S_LAST);

    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        b_cnt_d      = b_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        din_d        = din_q;
        wr_d         = 1'b0;
        ferr_d       = 1'b0;
        perr_pulse_d = 1'b0;
        ovr_d        = 1'b0;
        div_clr      = 1'b0;

        // Explicit wrap keeps the count correct when OVERSAMPLE is not a power of two.
        if (tick) begin
            s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + S_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                    div_clr = 1'b1;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (sample_mid) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        s_cnt_d = '0;
                        b_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (sample_last) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    b_cnt_d = b_cnt_q + B_W'(1);
                    if (b_cnt_q == B_LAST) begin
                        state_d = parity_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample_last) begin
                    perr_d  = (^shift_q) ^ rxs_q ^ parity_odd;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_last) begin
                    if (!rxs_q) begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else begin
                        state_d      = IDLE;
                        perr_pulse_d = perr_q;
                        if (fifo_full) begin
                            ovr_d = 1'b1;
                        end else begin
                            wr_d  = 1'b1;
                            din_d = shift_q;
                        end
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s_cnt_q      <= '0;
            b_cnt_q      <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            din_q        <= '0;
            wr_q         <= 1'b0;
            ferr_q       <= 1'b0;
            perr_pulse_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            b_cnt_q      <= b_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            din_q        <= din_d;
            wr_q         <= wr_d;
            ferr_q       <= ferr_d;
            perr_pulse_q <= perr_pulse_d;
            ovr_q        <= ovr_d;
        end
    end

    assign fifo_din   = din_q;
    assign fifo_wr_en = wr_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_pulse_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the DUT raises any output strobe.
module tb_uart_rx_deser;

    localparam int BIT_CLK = 64;  // baud_div=3 -> tick every 4 clk, 16 ticks per bit

    logic        wr_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        fifo_full = 1'b0;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        busy;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    // Event flags: {write, frame_err, parity_err, overrun}
    typedef struct {
        logic [3:0] flags;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    uart_rx_deser dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic void expect_ev(input logic [3:0] flags, input logic [7:0] data);
        ev_t e;
        e.flags = flags;
        e.data  = data;
        exp_q.push_back(e);
    endfunction

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, " fifo_din"},   fifo_din, 8'h00);
        check1({tag, " fifo_wr_en"}, {7'd0, fifo_wr_en}, 8'h00);
        check1({tag, " busy"},       {7'd0, busy}, 8'h00);
        check1({tag, " frame_err"},  {7'd0, frame_err}, 8'h00);
        check1({tag, " parity_err"}, {7'd0, parity_err}, 8'h00);
        check1({tag, " overrun"},    {7'd0, overrun}, 8'h00);
    endtask

    // Monitor: every output strobe must match the next expected event.
    initial begin
        ev_t e;
        logic [3:0] got;
        forever begin
            @(negedge wr_clk);
            got = {fifo_wr_en, frame_err, parity_err, overrun};
            if (got != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious output: flags %b data %h, expected none", got, fifo_din);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.flags || (e.flags[3] && fifo_din !== e.data)) begin
                        errors++;
                        $display("FAIL event: flags %b data %h, expected flags %b data %h",
                                 got, fifo_din, e.flags, e.data);
                    end else begin
                        $display("ok   event: flags %b data %h", got, fifo_din);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (BIT_CLK) @(posedge wr_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * BIT_CLK) @(posedge wr_clk);
        #1;
    endtask

    initial begin
        repeat (4) @(posedge wr_clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        idle_bits(2);

        // Basic byte
        expect_ev(4'b1000, 8'hA5);
        send_frame(8'hA5, 0, 1'b0, 1'b1);
        idle_bits(2);

        // Glitch shorter than half a bit
        rx_i = 1'b0;
        repeat (20) @(posedge wr_clk);
        #1;
        idle_bits(2);
        check1("glitch busy", {7'd0, busy}, 8'h00);

        // Parity: even/good, even/bad, odd/good
        parity_en = 1'b1;
        parity_odd = 1'b0;
        expect_ev(4'b1000, 8'h07);
        send_frame(8'h07, 1, 1'b1, 1'b1);
        idle_bits(2);
        expect_ev(4'b1010, 8'h07);
        send_frame(8'h07, 1, 1'b0, 1'b1);
        idle_bits(2);
        parity_odd = 1'b1;
        expect_ev(4'b1000, 8'h07);
        send_frame(8'h07, 1, 1'b0, 1'b1);
        idle_bits(2);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // Framing error followed by break
        expect_ev(4'b0100, 8'h00);
        send_frame(8'h3C, 0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (200) @(posedge wr_clk);
        #1;
        check1("break busy", {7'd0, busy}, 8'h01);
        rx_i = 1'b1;
        repeat (10) @(posedge wr_clk);
        #1;
        check1("after break busy", {7'd0, busy}, 8'h00);
        idle_bits(2);
        expect_ev(4'b1000, 8'h55);
        send_frame(8'h55, 0, 1'b0, 1'b1);
        idle_bits(2);
        check1("fifo_din holds", fifo_din, 8'h55);

        // Overrun, then back-to-back frames
        fifo_full = 1'b1;
        expect_ev(4'b0001, 8'h00);
        send_frame(8'h11, 0, 1'b0, 1'b1);
        idle_bits(2);
        fifo_full = 1'b0;
        check1("fifo_din after overrun", fifo_din, 8'h55);
        expect_ev(4'b1000, 8'h22);
        expect_ev(4'b1000, 8'h33);
        send_frame(8'h22, 0, 1'b0, 1'b1);
        send_frame(8'h33, 0, 1'b0, 1'b1);
        idle_bits(2);

        // Reset after four data bits of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        @(posedge wr_clk);
        #1;
        check_idle_outputs("midframe reset");
        rst = 1'b0;
        idle_bits(2);
        expect_ev(4'b1000, 8'h81);
        send_frame(8'h81, 0, 1'b0, 1'b1);
        idle_bits(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing events: %0d outstanding, expected 0", exp_q.size());
        end else begin
            $display("ok   all expected events seen");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
